// File: rtl/program_loader_pkg.sv
// Shared loader types and instruction-memory geometry defaults.
// Used by the loader, the instruction RAM and the core.
package program_loader_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 24;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_BYTE,
    S_WRITE,
    S_ACK,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Down-counter watchdog: reload on i_load, count while i_en, o_expired once LIMIT enabled cycles pass.
// Expiry is flagged in the LIMIT-th enabled cycle after a load; LIMIT=0 reads as always expired.
module loader_timeout #(
  parameter int LIMIT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] RELOAD = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= RELOAD;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/program_loader.sv
// Streams UART bytes into big-endian words and writes them to instruction RAM while holding the CPU.
// One byte per cycle in LEN/BYTE only; each word waits for its RAM ack; all outputs registered.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 1_000_000,
  parameter int ACK_TIMEOUT  = 8,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  input  logic              i_ram_ack,
  output logic              o_busy,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_words_written
);

  localparam int BPW  = DATA_W / 8;
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;

  loader_state_t r_state, w_next;

  logic              r_rx_ready;
  logic              r_we;
  logic              r_busy;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W:0]   r_len;
  logic [IDXW-1:0]   r_byte_idx;

  logic            w_xfer;
  logic            w_idle_like;
  logic            w_start_ok;
  logic            w_last_byte;
  logic [ADDR_W:0] w_words_inc;
  logic            w_final;
  logic            w_byte_exp;
  logic            w_byte_to;
  logic            w_ack_exp;

  assign w_xfer      = i_rx_valid & r_rx_ready;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_start_ok  = i_start & w_idle_like;
  assign w_last_byte = (r_byte_idx == IDXW'(BPW - 1));
  assign w_words_inc = r_words + {{ADDR_W{1'b0}}, 1'b1};
  assign w_final     = (w_words_inc == r_len);
  assign w_byte_to   = (BYTE_TIMEOUT != 0) && w_byte_exp;

  // Idle time spent waiting on the RAM is not charged to the host.
  loader_timeout #(.LIMIT(BYTE_TIMEOUT)) u_byte_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_xfer | w_start_ok),
    .i_en      ((r_state == S_LEN) || (r_state == S_BYTE)),
    .o_expired (w_byte_exp)
  );

  loader_timeout #(.LIMIT(ACK_TIMEOUT)) u_ack_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (r_state == S_WRITE),
    .i_en      (r_state == S_ACK),
    .o_expired (w_ack_exp)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_LEN;
      S_LEN: begin
        if (w_xfer)         w_next = S_BYTE;
        else if (w_byte_to) w_next = S_ERR;
      end
      S_BYTE: begin
        if (w_xfer && w_last_byte) w_next = S_WRITE;
        else if (!w_xfer && w_byte_to) w_next = S_ERR;
      end
      S_WRITE: w_next = S_ACK;
      S_ACK: begin
        if (i_ram_ack)      w_next = w_final ? S_DONE : S_BYTE;
        else if (w_ack_exp) w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= (w_next == S_LEN) || (w_next == S_BYTE);
      r_we       <= (w_next == S_WRITE);
      r_busy     <= (w_next == S_LEN) || (w_next == S_BYTE) ||
                    (w_next == S_WRITE) || (w_next == S_ACK);
      r_cpu_hold <= (w_next == S_LEN) || (w_next == S_BYTE) ||
                    (w_next == S_WRITE) || (w_next == S_ACK);
      r_done     <= (w_next == S_DONE);
      r_error    <= (w_next == S_ERR);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_words    <= '0;
      r_len      <= '0;
      r_byte_idx <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_addr     <= '0;
            r_words    <= '0;
            r_byte_idx <= '0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_len <= (i_rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                         : (ADDR_W + 1)'(i_rx_data);
          end
        end
        S_BYTE: begin
          if (w_xfer) begin
            r_data     <= (r_data << 8) | DATA_W'(i_rx_data);
            r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
          end
        end
        S_ACK: begin
          if (i_ram_ack) begin
            r_words <= w_words_inc;
            // The final word keeps its address so a full-depth load never wraps to 0.
            if (!w_final) r_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rx_ready      = r_rx_ready;
  assign o_ram_we        = r_we;
  assign o_ram_addr      = r_addr;
  assign o_ram_data      = r_data;
  assign o_busy          = r_busy;
  assign o_cpu_hold      = r_cpu_hold;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_words_written = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized loads checked against a byte-stream-to-memory reference model.
module tb_program_loader;

  localparam int BT = 16;
  localparam int AT = 8;
  localparam int AW = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_ack;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_written;

  always #5 clk = ~clk;

  program_loader #(
    .BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
    .i_ram_ack(ram_ack), .o_busy(busy), .o_cpu_hold(cpu_hold),
    .o_done(done), .o_error(error), .o_words_written(words_written)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic [7:0]    tx_q[$];
  logic [DW-1:0] exp_w[$];
  bit            ack_en = 1'b1;
  bit            ack_pending = 1'b0;
  bit            we_prev = 1'b0;
  int            viol = 0;

  // RAM model: records every write strobe and acks in the following cycle.
  initial begin
    ram_ack = 1'b0;
    forever begin
      @(negedge clk);
      ram_ack     = ack_pending;
      ack_pending = 1'b0;
      if (ram_we === 1'b1) begin
        mem[ram_addr] = ram_data;
        wr_addr.push_back(ram_addr);
        wr_data.push_back(ram_data);
        if (ack_en) ack_pending = 1'b1;
      end
    end
  end

  // The ACK cycle is the one right after the write strobe; no byte may be offered then.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_ready && (ram_we || we_prev)) viol++;
      we_prev = ram_we;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    rx_data  = b;
    rx_valid = 1'b1;
    ok       = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (rx_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_tx(input int gap_max);
    int lost;
    bit ok;
    lost = 0;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], ok);
      if (!ok) lost++;
      if (gap_max > 0) begin
        int gap;
        gap = $urandom_range(0, gap_max);
        if (gap > 0) begin
          rx_valid = 1'b0;
          repeat (gap) @(negedge clk);
        end
      end
    end
    rx_valid = 1'b0;
    check("bytes_accepted_lost", lost, 0);
  endtask

  task automatic wait_end(input int bound);
    int cyc;
    cyc = 0;
    while (!(done || error) && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check("load_finished_in_time", (cyc < bound), 1);
  endtask

  // Reference model: N words from a 3-byte big-endian stream land at addresses 0..N-1.
  task automatic do_load(input int n, input int gap_max);
    int bad;
    logic [7:0] b0, b1, b2;
    tx_q.delete();
    exp_w.delete();
    wr_addr.delete();
    wr_data.delete();
    tx_q.push_back(8'(n % 256));
    for (int i = 0; i < n; i++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      tx_q.push_back(b0);
      tx_q.push_back(b1);
      tx_q.push_back(b2);
      exp_w.push_back({b0, b1, b2});
    end
    pulse_start();
    run_tx(gap_max);
    wait_end(5000);
    check("load_done", done, 1);
    check("load_error", error, 0);
    check("load_words_written", words_written, n);
    check("load_busy_low", busy, 0);
    check("load_cpu_hold_low", cpu_hold, 0);
    check("load_write_count", wr_addr.size(), n);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= wr_addr.size()) bad++;
      else if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp_w[i] || mem[i] !== exp_w[i]) bad++;
    end
    check("load_word_mismatches", bad, 0);
  endtask

  initial begin
    int cyc;
    int we_cyc;
    int moved;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;

    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ctrl", {rx_ready, ram_we, busy, cpu_hold, done, error}, 0);
    check("reset_addr", ram_addr, 0);
    check("reset_data", ram_data, 0);
    check("reset_words", words_written, 0);

    // Directed two-word load.
    tx_q = '{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check("start_busy", busy, 1);
    check("start_cpu_hold", cpu_hold, 1);
    run_tx(0);
    wait_end(200);
    check("dir_mem0", mem[0], 24'hAABBCC);
    check("dir_mem1", mem[1], 24'h112233);
    check("dir_done", done, 1);
    check("dir_words", words_written, 2);
    check("dir_busy_low", busy, 0);

    // Full-depth load: N=0 means 256 words, last address 255, no wrap.
    do_load(256, 1);
    check("full_final_addr", ram_addr, 255);

    for (int k = 0; k < 3; k++) do_load($urandom_range(1, 12), 2);

    // Byte timeout in the middle of a word.
    wr_addr.delete();
    wr_data.delete();
    tx_q = '{8'h01, 8'hAA, 8'hBB};
    pulse_start();
    run_tx(0);
    cyc = 0;
    while (!error && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("bto_latency_in_range", (cyc >= BT - 1 && cyc <= BT + 1), 1);
    check("bto_error", error, 1);
    check("bto_done", done, 0);
    check("bto_no_write", wr_addr.size(), 0);
    check("bto_words", words_written, 0);
    check("bto_busy_low", busy, 0);

    // RAM never acks.
    ack_en = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    tx_q = '{8'h01, 8'h12, 8'h34, 8'h56};
    pulse_start();
    run_tx(0);
    a0 = ram_addr;
    d0 = ram_data;
    we_cyc = 0;
    moved = 0;
    cyc = 0;
    while (!error && cyc < 40) begin
      if (ram_we) we_cyc++;
      if (ram_addr !== a0 || ram_data !== d0) moved++;
      @(negedge clk);
      cyc++;
    end
    check("ato_we_cycles", we_cyc, 1);
    check("ato_stable", moved, 0);
    check("ato_addr", a0, 0);
    check("ato_data", d0, 24'h123456);
    check("ato_latency_in_range", (cyc >= AT && cyc <= AT + 2), 1);
    check("ato_error", error, 1);
    check("ato_words", words_written, 0);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-word, then a clean reload.
    tx_q = '{8'h02, 8'h11, 8'h22};
    pulse_start();
    run_tx(0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctrl", {rx_ready, ram_we, busy, cpu_hold, done, error}, 0);
    check("rst_mid_addr", ram_addr, 0);
    check("rst_mid_data", ram_data, 0);
    check("rst_mid_words", words_written, 0);
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    tx_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE};
    pulse_start();
    run_tx(1);
    wait_end(200);
    check("rst_reload_mem0", mem[0], 24'hDEADBE);
    check("rst_reload_writes", wr_addr.size(), 1);
    check("rst_reload_done", done, 1);

    // start while busy is ignored; bytes held valid across WRITE/ACK are neither lost nor doubled.
    wr_addr.delete();
    wr_data.delete();
    tx_q = '{8'h02, 8'hA1};
    pulse_start();
    run_tx(0);
    check("busy_before_restart", busy, 1);
    pulse_start();
    tx_q = '{8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    run_tx(0);
    wait_end(200);
    check("hold_mem0", mem[0], 24'hA1A2A3);
    check("hold_mem1", mem[1], 24'hB1B2B3);
    check("hold_writes", wr_addr.size(), 2);
    check("hold_words", words_written, 2);
    check("hold_done", done, 1);

    check("rx_ready_in_write_ack", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
